// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit feeder slice.
package uart_pkg;

   localparam int UART_DATA_W      = 8;
   localparam int UART_FIFO_DEPTH  = 16;
   localparam int UART_ACK_TIMEOUT = 65535;
   localparam int UART_TO_W        = 16;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SEND
   } tx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Circular DEPTH x byte FIFO with occupancy count; writes to a full FIFO are ignored.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH  = UART_FIFO_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [UART_DATA_W-1:0] wr_data,
   input  logic                   rd_en,
   output logic [UART_DATA_W-1:0] rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [ADDR_W:0]        count
);

   localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   logic [UART_DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0]      wr_ptr;
   logic [ADDR_W-1:0]      rd_ptr;
   logic                   push;
   logic                   pop;

   assign full    = (count == CNT_FULL);
   assign empty   = (count == '0);
   assign push    = wr_en && !full;
   assign pop     = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   // Storage carries no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers host bytes and launches them one at a time into the UART transmitter,
// holding tx_start until the UART acknowledges with busy.
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int DEPTH       = UART_FIFO_DEPTH,
   parameter int ADDR_W      = $clog2(DEPTH),
   parameter int ACK_TIMEOUT = UART_ACK_TIMEOUT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   wr_en,
   input  logic [UART_DATA_W-1:0] wr_data,
   input  logic                   clr_err,
   input  logic                   busy,
   output logic                   tx_start,
   output logic                   tx_enable,
   output logic [UART_DATA_W-1:0] tx_data,
   output logic                   full,
   output logic                   empty,
   output logic [ADDR_W:0]        count,
   output logic                   sent,
   output logic                   overflow,
   output logic                   timeout_err
);

   localparam logic [UART_TO_W-1:0] TO_LIMIT = UART_TO_W'(ACK_TIMEOUT);
   localparam logic [UART_TO_W-1:0] TO_ONE   = UART_TO_W'(1);

   tx_state_t              state;
   tx_state_t              state_next;
   logic [UART_TO_W-1:0]   to_cnt;
   logic [UART_TO_W-1:0]   to_cnt_next;
   logic [UART_TO_W-1:0]   to_cnt_inc;
   logic                   pop;
   logic                   to_fire;
   logic                   byte_done;
   logic [UART_DATA_W-1:0] rd_data;

   function automatic logic [UART_TO_W-1:0] sat_inc(input logic [UART_TO_W-1:0] v);
      return (v == TO_LIMIT) ? v : v + TO_ONE;
   endfunction

   uart_sync_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_en   (pop),
      .rd_data (rd_data),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

   assign to_cnt_inc = sat_inc(to_cnt);

   // to_cnt holds the number of LOAD cycles already spent, so the request
   // gives up after exactly ACK_TIMEOUT cycles of tx_start without busy.
   always_comb begin
      state_next  = state;
      to_cnt_next = to_cnt;
      pop         = 1'b0;
      to_fire     = 1'b0;
      byte_done   = 1'b0;
      case (state)
         IDLE: begin
            if (en && !empty) begin
               pop         = 1'b1;
               to_cnt_next = '0;
               state_next  = LOAD;
            end
         end
         LOAD: begin
            if (busy) begin
               state_next = SEND;
            end else if (to_cnt_inc == TO_LIMIT) begin
               to_fire    = 1'b1;
               state_next = IDLE;
            end else begin
               to_cnt_next = to_cnt_inc;
            end
         end
         SEND: begin
            if (!busy) begin
               byte_done  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Sticky flags: a set event in the same cycle as clr_err wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         to_cnt      <= '0;
         tx_start    <= 1'b0;
         tx_enable   <= 1'b0;
         tx_data     <= '0;
         sent        <= 1'b0;
         overflow    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_next;
         to_cnt      <= to_cnt_next;
         tx_start    <= (state_next == LOAD);
         tx_enable   <= en;
         sent        <= byte_done;
         overflow    <= (wr_en && full) || (overflow && !clr_err);
         timeout_err <= to_fire || (timeout_err && !clr_err);
         if (pop) begin
            tx_data <= rd_data;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: handshake, FIFO fill/overflow, wrap, timeout, reset and en gating.
module tb_uart_tx_feeder;
   import uart_pkg::*;

   localparam int DEPTH       = 16;
   localparam int ADDR_W      = 4;
   localparam int ACK_TIMEOUT = 10;

   logic              clk = 1'b0;
   logic              rst;
   logic              en;
   logic              wr_en;
   logic [7:0]        wr_data;
   logic              clr_err;
   logic              busy;
   logic              tx_start;
   logic              tx_enable;
   logic [7:0]        tx_data;
   logic              full;
   logic              empty;
   logic [ADDR_W:0]   count;
   logic              sent;
   logic              overflow;
   logic              timeout_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   uart_tx_feeder #(
      .DEPTH       (DEPTH),
      .ADDR_W      (ADDR_W),
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .clr_err     (clr_err),
      .busy        (busy),
      .tx_start    (tx_start),
      .tx_enable   (tx_enable),
      .tx_data     (tx_data),
      .full        (full),
      .empty       (empty),
      .count       (count),
      .sent        (sent),
      .overflow    (overflow),
      .timeout_err (timeout_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic write_byte(input logic [7:0] b);
      wr_en   = 1'b1;
      wr_data = b;
      tick();
      wr_en   = 1'b0;
   endtask

   // Plays the UART side: busy rises two cycles into the request, is held
   // for 'hold' cycles, then falls; ends on the cycle sent should pulse.
   task automatic serve_byte(input logic [7:0] exp, input int hold);
      int waited;
      bit stable;
      waited = 0;
      stable = 1'b1;
      while (tx_start !== 1'b1 && waited < 40) begin
         tick();
         waited++;
      end
      chk("start_seen", 32'(tx_start), 1);
      chk("load_data", 32'(tx_data), 32'(exp));
      tick();
      chk("start_held", 32'(tx_start), 1);
      busy = 1'b1;
      tick();
      chk("start_drop", 32'(tx_start), 0);
      for (int i = 0; i < hold; i++) begin
         if (tx_start !== 1'b0 || tx_data !== exp || sent !== 1'b0) stable = 1'b0;
         tick();
      end
      chk("send_stable", 32'(stable), 1);
      busy = 1'b0;
      tick();
      chk("sent_pulse", 32'(sent), 1);
   endtask

   initial begin
      int hi;
      bit quiet;
      rst = 1'b1; en = 1'b0; wr_en = 1'b0; wr_data = 8'h00; clr_err = 1'b0; busy = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      chk("rst_tx_start", 32'(tx_start), 0);
      chk("rst_tx_enable", 32'(tx_enable), 0);
      chk("rst_tx_data", 32'(tx_data), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_sent", 32'(sent), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_timeout", 32'(timeout_err), 0);

      // Single byte 0xA5
      en = 1'b1;
      tick();
      chk("tx_enable_on", 32'(tx_enable), 1);
      write_byte(8'hA5);
      chk("t1_count", 32'(count), 1);
      chk("t1_no_start_yet", 32'(tx_start), 0);
      tick();
      chk("t1_start", 32'(tx_start), 1);
      chk("t1_data", 32'(tx_data), 32'h A5);
      chk("t1_popped", 32'(empty), 1);
      serve_byte(8'hA5, 100);
      tick();
      chk("t1_sent_once", 32'(sent), 0);
      chk("t1_idle", 32'(tx_start), 0);
      chk("t1_empty", 32'(empty), 1);

      // Fill with en low, overflow on the 17th write (set wins over clr_err)
      en = 1'b0;
      tick();
      chk("tx_enable_off", 32'(tx_enable), 0);
      for (int i = 0; i < 16; i++) write_byte(8'(i));
      chk("t2_full16", 32'(full), 1);
      chk("t2_count16", 32'(count), 16);
      chk("t2_no_ovf_yet", 32'(overflow), 0);
      clr_err = 1'b1;
      write_byte(8'hFF);
      clr_err = 1'b0;
      chk("t2_overflow", 32'(overflow), 1);
      chk("t2_count_kept", 32'(count), 16);
      chk("t2_idle_en0", 32'(tx_start), 0);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("t2_ovf_clr", 32'(overflow), 0);
      en = 1'b1;
      tick();
      chk("t2_first_pop", 32'(count), 15);
      for (int i = 0; i < 16; i++) begin
         serve_byte(8'(i), 3);
         tick();
         chk("t2_sent_clear", 32'(sent), 0);
         chk("t2_next_load", 32'(tx_start), (i < 15) ? 1 : 0);
      end
      quiet = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (tx_start !== 1'b0) quiet = 1'b0;
         tick();
      end
      chk("t2_no_ff", 32'(quiet), 1);
      chk("t2_empty", 32'(empty), 1);

      // Simultaneous push and pop at count 1, across the pointer wrap
      en = 1'b0;
      tick();
      write_byte(8'h30);
      chk("t3_count1", 32'(count), 1);
      for (int k = 0; k < 18; k++) begin
         en = 1'b1;
         wr_en = 1'b1;
         wr_data = 8'(8'h31 + k);
         tick();
         wr_en = 1'b0;
         chk("t3_count_hold", 32'(count), 1);
         chk("t3_launch", 32'(tx_start), 1);
         serve_byte(8'(8'h30 + k), 2);
      end
      tick();
      chk("t3_last_pop", 32'(count), 0);
      serve_byte(8'h42, 2);
      tick();
      chk("t3_empty", 32'(empty), 1);

      // Ack timeout with busy stuck low
      en = 1'b0;
      write_byte(8'h55);
      write_byte(8'h66);
      en = 1'b1;
      tick();
      chk("t4_data", 32'(tx_data), 32'h55);
      hi = 0;
      for (int i = 0; i < 20; i++) begin
         if (tx_start !== 1'b1) break;
         hi++;
         tick();
      end
      chk("t4_start_cycles", 32'(hi), ACK_TIMEOUT);
      chk("t4_timeout_err", 32'(timeout_err), 1);
      chk("t4_no_sent", 32'(sent), 0);
      tick();
      chk("t4_next_launch", 32'(tx_start), 1);
      chk("t4_next_data", 32'(tx_data), 32'h66);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("t4_err_clr", 32'(timeout_err), 0);
      serve_byte(8'h66, 3);
      tick();
      chk("t4_empty", 32'(empty), 1);

      // Reset while in SEND with 3 bytes queued
      en = 1'b0;
      for (int i = 1; i <= 4; i++) write_byte(8'(i));
      en = 1'b1;
      tick();
      chk("t5_load", 32'(tx_data), 1);
      busy = 1'b1;
      tick();
      chk("t5_in_send", 32'(tx_start), 0);
      chk("t5_queued", 32'(count), 3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      busy = 1'b0;
      chk("t5_count", 32'(count), 0);
      chk("t5_empty", 32'(empty), 1);
      chk("t5_start", 32'(tx_start), 0);
      chk("t5_sent", 32'(sent), 0);
      chk("t5_tx_data", 32'(tx_data), 0);
      tick();
      chk("t5_no_sent", 32'(sent), 0);
      chk("t5_no_start", 32'(tx_start), 0);

      // Drop en mid-SEND
      en = 1'b0;
      write_byte(8'h77);
      write_byte(8'h88);
      en = 1'b1;
      tick();
      chk("t6_load", 32'(tx_data), 32'h77);
      tick();
      busy = 1'b1;
      tick();
      chk("t6_send", 32'(tx_start), 0);
      en = 1'b0;
      tick();
      tick();
      chk("t6_enable_low", 32'(tx_enable), 0);
      busy = 1'b0;
      tick();
      chk("t6_sent", 32'(sent), 1);
      quiet = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (tx_start !== 1'b0) quiet = 1'b0;
      end
      chk("t6_blocked", 32'(quiet), 1);
      chk("t6_count", 32'(count), 1);
      en = 1'b1;
      tick();
      chk("t6_resume", 32'(tx_start), 1);
      chk("t6_resume_data", 32'(tx_data), 32'h88);
      serve_byte(8'h88, 3);
      tick();
      chk("t6_empty", 32'(empty), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
